thread_scheduler: RTL

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

---
 rtl/thread_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin fetch thread selector for an 8-thread core.
// Picks one eligible thread (valid & running) per request, holds the request
// until fetch accepts it, and produces per-thread PC write-backs for both
// sequential advance (pc+4 on accept) and branch/jump redirects.
//
// Optional build macro THREAD_SCHED_IDLE_CNT_EN: when defined, idle_cnt counts
// (saturating) the cycles in which no thread is eligible; otherwise idle_cnt
// is tied to zero and no counter flops exist.
//
// Fetch handshake: a request is offered while fetch_vld=1 and transfers on
// every rising edge where fetch_vld & fetch_rdy are both 1. While offered and
// not yet transferred, fetch_trd/fetch_pc are held stable unless the request
// is withdrawn (pending thread hit by a redirect, or no longer eligible).
module thread_scheduler (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   valid,
    input  logic [7:0]   running,
    input  logic [255:0] trd_pc,
    input  logic         br_vld,
    input  logic [2:0]   br_trd,
    input  logic [31:0]  br_pc,
    input  logic         fetch_rdy,
    output logic         fetch_vld,
    output logic [2:0]   fetch_trd,
    output logic [31:0]  fetch_pc,
    output logic [7:0]   pc_wr,
    output logic [255:0] nxt_pc,
    output logic [31:0]  idle_cnt,
    output logic         dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  trd_q, trd_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;

    logic [7:0]  eligible;
    logic        accept;
    logic        withdraw;
    logic        reselect;
    logic [2:0]  search_base;
    logic        win_found;
    logic [2:0]  win_trd;
    logic [31:0] win_pc;
    logic [7:0]  pc_wr_c;
    logic [255:0] nxt_pc_c;

    assign eligible    = valid & running;
    assign accept      = (state_q == S_ISSUE) & fetch_rdy;
    // Pending request is dropped when its thread is redirected or leaves the
    // eligible set before fetch takes it.
    assign withdraw    = (state_q == S_ISSUE) & ~fetch_rdy &
                         (~eligible[trd_q] | (br_vld & (br_trd == trd_q)));
    assign reselect    = (state_q == S_IDLE) | accept | withdraw;
    // After an accept the accepted thread becomes the new round-robin pointer,
    // so the search for the back-to-back winner starts just past it.
    assign search_base = accept ? trd_q : rr_ptr_q;

    // Round-robin pick: first eligible thread at search_base+1 .. search_base+8.
    always_comb begin
        logic [2:0] idx;
        win_found = 1'b0;
        win_trd   = 3'd0;
        idx       = 3'd0;
        // Walk from farthest to nearest so the nearest eligible thread wins.
        for (int k = 8; k >= 1; k--) begin
            idx = search_base + 3'(k);
            if (eligible[idx]) begin
                win_found = 1'b1;
                win_trd   = idx;
            end
        end
    end

    // PC write-back: sequential advance on accept, redirect overrides on the same thread.
    always_comb begin
        pc_wr_c  = 8'd0;
        nxt_pc_c = 256'd0;
        if (rst_n) begin
            if (accept) begin
                pc_wr_c[trd_q]                    = 1'b1;
                nxt_pc_c[{trd_q, 5'd0} +: 32]     = pc_q + 32'd4;
            end
            if (br_vld) begin
                pc_wr_c[br_trd]                   = 1'b1;
                nxt_pc_c[{br_trd, 5'd0} +: 32]    = br_pc;
            end
        end
    end

    // Winner PC: forward this cycle's write-back so a thread reselected on the
    // same edge its PC is updated fetches from the updated PC.
    always_comb begin
        win_pc = trd_pc[{win_trd, 5'd0} +: 32];
        if (pc_wr_c[win_trd]) begin
            win_pc = nxt_pc_c[{win_trd, 5'd0} +: 32];
        end
    end

    // State register: FSM state, pending request and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            trd_q    <= 3'd0;
            pc_q     <= 32'd0;
            rr_ptr_q <= 3'd7;
        end else begin
            state_q  <= state_d;
            trd_q    <= trd_d;
            pc_q     <= pc_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state: issue the round-robin winner whenever a new request is needed.
    always_comb begin
        state_d  = state_q;
        trd_d    = trd_q;
        pc_d     = pc_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = trd_q;
        end
        if (reselect) begin
            if (win_found) begin
                state_d = S_ISSUE;
                trd_d   = win_trd;
                pc_d    = win_pc;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Outputs: request is valid exactly while in ISSUE.
    always_comb begin
        fetch_vld = (state_q == S_ISSUE);
        fetch_trd = trd_q;
        fetch_pc  = pc_q;
        pc_wr     = pc_wr_c;
        nxt_pc    = nxt_pc_c;
        dbg_state = state_q;
    end

`ifdef THREAD_SCHED_IDLE_CNT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Idle counter next value: count empty-eligible cycles, saturate at all-ones.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if ((eligible == 8'd0) && (idle_cnt_q != 32'hFFFF_FFFF)) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign idle_cnt = idle_cnt_q;
`else
    assign idle_cnt = 32'd0;
`endif

endmodule
